// File: rtl/force_wb_arbiter.sv
// force_wb_arbiter: shares one force-cache read-modify-write port between the
// local force pipelines and remote ring writebacks. Grants are round-robin.
// A pid stays hazard-blocked until its previous write has committed.
// Optional feature: define FORCE_WB_MERGE_EN to combine equal-pid requests
// from both sides into a single read-modify-write.
module force_wb_arbiter #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int FORCE_WIDTH       = 32,
  parameter int CACHE_RD_LATENCY  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         local_valid,
  output logic                         local_ready,
  input  logic [PARTICLE_ID_WIDTH-1:0] local_pid,
  input  logic [3*FORCE_WIDTH-1:0]     local_force,
  input  logic                         remote_valid,
  output logic                         remote_ready,
  input  logic [PARTICLE_ID_WIDTH-1:0] remote_pid,
  input  logic [3*FORCE_WIDTH-1:0]     remote_force,
  output logic                         cache_rd_en,
  output logic [PARTICLE_ID_WIDTH-1:0] cache_rd_addr,
  input  logic [3*FORCE_WIDTH-1:0]     cache_rd_data,
  output logic                         cache_wr_en,
  output logic [PARTICLE_ID_WIDTH-1:0] cache_wr_addr,
  output logic [3*FORCE_WIDTH-1:0]     cache_wr_data,
  output logic                         wb_idle
);

  localparam int WIN_DEPTH  = CACHE_RD_LATENCY + 1;
  localparam int DATA_WIDTH = 3 * FORCE_WIDTH;

  // Adds the three force components independently; each wraps on its own.
  function automatic logic [DATA_WIDTH-1:0] add3(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] sum;
    sum = '0;
    for (int c = 0; c < 3; c++) begin
      sum[c*FORCE_WIDTH +: FORCE_WIDTH] = a[c*FORCE_WIDTH +: FORCE_WIDTH] +
                                          b[c*FORCE_WIDTH +: FORCE_WIDTH];
    end
    return sum;
  endfunction

  logic                         win_valid  [WIN_DEPTH];
  logic [PARTICLE_ID_WIDTH-1:0] win_pid    [WIN_DEPTH];
  logic                         pipe_valid [CACHE_RD_LATENCY];
  logic [PARTICLE_ID_WIDTH-1:0] pipe_pid   [CACHE_RD_LATENCY];
  logic [DATA_WIDTH-1:0]        pipe_delta [CACHE_RD_LATENCY];
  logic                         rr_ptr;

  logic                         local_hit;
  logic                         remote_hit;
  logic                         win_any;
  logic                         pipe_any;
  logic                         local_elig;
  logic                         remote_elig;
  logic                         merge_hit;
  logic                         grant_local;
  logic                         grant_remote;
  logic                         grant_any;
  logic [PARTICLE_ID_WIDTH-1:0] grant_pid;
  logic [DATA_WIDTH-1:0]        grant_delta;

  // Compare both requesters' pids against every live hazard-window entry.
  always_comb begin
    local_hit  = 1'b0;
    remote_hit = 1'b0;
    win_any    = 1'b0;
    pipe_any   = 1'b0;
    for (int i = 0; i < WIN_DEPTH; i++) begin
      if (win_valid[i]) begin
        win_any = 1'b1;
        if (win_pid[i] == local_pid)  local_hit  = 1'b1;
        if (win_pid[i] == remote_pid) remote_hit = 1'b1;
      end
    end
    for (int i = 0; i < CACHE_RD_LATENCY; i++) begin
      if (pipe_valid[i]) pipe_any = 1'b1;
    end
  end

  // Pick at most one winner by round-robin, or both when an equal-pid merge applies.
  always_comb begin
    merge_hit    = 1'b0;
    grant_local  = 1'b0;
    grant_remote = 1'b0;
    local_elig   = local_valid && !local_hit && !rst;
    remote_elig  = remote_valid && !remote_hit && !rst;
`ifdef FORCE_WB_MERGE_EN
    merge_hit    = local_elig && remote_elig && (local_pid == remote_pid);
`endif
    if (merge_hit) begin
      grant_local  = 1'b1;
      grant_remote = 1'b1;
    end else if (!rr_ptr) begin
      if (local_elig)       grant_local  = 1'b1;
      else if (remote_elig) grant_remote = 1'b1;
    end else begin
      if (remote_elig)      grant_remote = 1'b1;
      else if (local_elig)  grant_local  = 1'b1;
    end
  end

  // Select the pid and delta that travel with this cycle's grant.
  always_comb begin
    grant_any   = grant_local || grant_remote;
    grant_pid   = '0;
    grant_delta = '0;
    if (merge_hit) begin
      grant_pid   = local_pid;
      grant_delta = add3(local_force, remote_force);
    end else if (grant_local) begin
      grant_pid   = local_pid;
      grant_delta = local_force;
    end else if (grant_remote) begin
      grant_pid   = remote_pid;
      grant_delta = remote_force;
    end
  end

  assign local_ready   = grant_local;
  assign remote_ready  = grant_remote;
  assign cache_rd_en   = grant_any;
  assign cache_rd_addr = grant_pid;
  assign wb_idle       = !local_valid && !remote_valid && !win_any && !pipe_any && !cache_wr_en;

  // Shift the hazard window and the delta pipeline, and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win_valid[i] <= 1'b0;
        win_pid[i]   <= '0;
      end
      for (int i = 0; i < CACHE_RD_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_pid[i]   <= '0;
        pipe_delta[i] <= '0;
      end
      rr_ptr <= 1'b0;
    end else begin
      win_valid[0]  <= grant_any;
      win_pid[0]    <= grant_pid;
      for (int i = 1; i < WIN_DEPTH; i++) begin
        win_valid[i] <= win_valid[i-1];
        win_pid[i]   <= win_pid[i-1];
      end
      pipe_valid[0] <= grant_any;
      pipe_pid[0]   <= grant_pid;
      pipe_delta[0] <= grant_delta;
      for (int i = 1; i < CACHE_RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_pid[i]   <= pipe_pid[i-1];
        pipe_delta[i] <= pipe_delta[i-1];
      end
      if (grant_local && !grant_remote)      rr_ptr <= 1'b1;
      else if (grant_remote && !grant_local) rr_ptr <= 1'b0;
    end
  end

  // Accumulate the returning cache data with its delta and register the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_wr_en   <= 1'b0;
      cache_wr_addr <= '0;
      cache_wr_data <= '0;
    end else begin
      cache_wr_en <= pipe_valid[CACHE_RD_LATENCY-1];
      if (pipe_valid[CACHE_RD_LATENCY-1]) begin
        cache_wr_addr <= pipe_pid[CACHE_RD_LATENCY-1];
        cache_wr_data <= add3(cache_rd_data, pipe_delta[CACHE_RD_LATENCY-1]);
      end
    end
  end

endmodule

// File: tb/tb_force_wb_arbiter.sv
// tb_force_wb_arbiter: directed scoreboard bench for force_wb_arbiter with a
// behavioural force cache. Expected writes are queued up front and
// compared by a monitor whenever cache_wr_en is seen. Honours FORCE_WB_MERGE_EN.
module tb_force_wb_arbiter;

  localparam int PW = 7;
  localparam int FW = 32;
  localparam int L  = 2;
  localparam int DW = 3 * FW;

  typedef struct { logic [PW-1:0] pid; logic [DW-1:0] delta; } req_t;
  typedef struct { logic [PW-1:0] addr; logic [DW-1:0] data; } exp_t;
  typedef struct { int cyc; bit who; logic [PW-1:0] pid; } grant_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          local_valid, remote_valid;
  logic          local_ready, remote_ready;
  logic [PW-1:0] local_pid, remote_pid;
  logic [DW-1:0] local_force, remote_force;
  logic          cache_rd_en, cache_wr_en, wb_idle;
  logic [PW-1:0] cache_rd_addr, cache_wr_addr;
  logic [DW-1:0] cache_rd_data, cache_wr_data;

  logic          pre_en = 1'b0;
  logic [PW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic [DW-1:0] mem     [128];
  logic [DW-1:0] rd_pipe [L];

  req_t   lq[$];
  req_t   rq[$];
  exp_t   expq[$];
  grant_t glog[$];
  int     rdq[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  force_wb_arbiter #(.PARTICLE_ID_WIDTH(PW), .FORCE_WIDTH(FW), .CACHE_RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .local_valid(local_valid), .local_ready(local_ready),
    .local_pid(local_pid), .local_force(local_force),
    .remote_valid(remote_valid), .remote_ready(remote_ready),
    .remote_pid(remote_pid), .remote_force(remote_force),
    .cache_rd_en(cache_rd_en), .cache_rd_addr(cache_rd_addr), .cache_rd_data(cache_rd_data),
    .cache_wr_en(cache_wr_en), .cache_wr_addr(cache_wr_addr), .cache_wr_data(cache_wr_data),
    .wb_idle(wb_idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural force cache: preload port, write port and fixed-latency read.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (cache_wr_en) mem[cache_wr_addr] <= cache_wr_data;
    rd_pipe[0] <= cache_rd_en ? mem[cache_rd_addr] : '0;
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign cache_rd_data = rd_pipe[L-1];

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit side, input logic [PW-1:0] pid, input logic [DW-1:0] delta);
    req_t r;
    r.pid = pid;
    r.delta = delta;
    if (side) rq.push_back(r);
    else lq.push_back(r);
  endtask

  task automatic expectWrite(input logic [PW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    expq.push_back(e);
  endtask

  task automatic preload(input logic [PW-1:0] addr, input logic [DW-1:0] data);
    pre_en = 1'b1;
    pre_addr = addr;
    pre_data = data;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic waitGrants(input int n);
    int budget;
    budget = 0;
    while (glog.size() < n && budget < 200) begin
      tick();
      budget++;
    end
    checkOutput("grant wait timeout", DW'(glog.size() >= n), DW'(1));
  endtask

  task automatic waitIdle();
    int budget;
    budget = 0;
    while (!(lq.size() == 0 && rq.size() == 0 && expq.size() == 0 && wb_idle) && budget < 500) begin
      tick();
      budget++;
    end
    checkOutput("idle wait timeout", DW'(budget < 500), DW'(1));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " local_ready"}, DW'(local_ready), '0);
    checkOutput({tag, " remote_ready"}, DW'(remote_ready), '0);
    checkOutput({tag, " cache_rd_en"}, DW'(cache_rd_en), '0);
    checkOutput({tag, " cache_rd_addr"}, DW'(cache_rd_addr), '0);
    checkOutput({tag, " cache_wr_en"}, DW'(cache_wr_en), '0);
    checkOutput({tag, " cache_wr_addr"}, DW'(cache_wr_addr), '0);
    checkOutput({tag, " cache_wr_data"}, cache_wr_data, '0);
    checkOutput({tag, " wb_idle"}, DW'(wb_idle), DW'(1));
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    checkReset("reset");
    rst = 1'b0;
  endtask

  // Request driver: presents queue heads each cycle and logs observed grants.
  initial begin
    local_valid = 1'b0; local_pid = '0; local_force = '0;
    remote_valid = 1'b0; remote_pid = '0; remote_force = '0;
    forever begin
      @(posedge clk);
      #1;
      local_valid = (lq.size() > 0);
      if (lq.size() > 0) begin local_pid = lq[0].pid; local_force = lq[0].delta; end
      remote_valid = (rq.size() > 0);
      if (rq.size() > 0) begin remote_pid = rq[0].pid; remote_force = rq[0].delta; end
      @(negedge clk);
      if (!local_valid) checkOutput("local_ready without valid", DW'(local_ready), '0);
      if (!remote_valid) checkOutput("remote_ready without valid", DW'(remote_ready), '0);
      if (local_valid && local_ready) begin
        glog.push_back('{cyc, 1'b0, local_pid});
        void'(lq.pop_front());
      end
      if (remote_valid && remote_ready) begin
        glog.push_back('{cyc, 1'b1, remote_pid});
        void'(rq.pop_front());
      end
    end
  end

  // Monitor: every cache write is matched against the next expected write and its read.
  always @(negedge clk) begin
    exp_t e;
    int rc;
    if (rst) begin
      rdq.delete();
    end else begin
      if (cache_rd_en) rdq.push_back(cyc);
      if (cache_wr_en) begin
        wr_count++;
        if (expq.size() == 0) begin
          checkOutput("unexpected write addr", DW'(cache_wr_addr), '1);
        end else begin
          e = expq.pop_front();
          checkOutput("write addr", DW'(cache_wr_addr), DW'(e.addr));
          checkOutput("write data", cache_wr_data, e.data);
          if (rdq.size() == 0) begin
            checkOutput("write without read", DW'(0), DW'(1));
          end else begin
            rc = rdq.pop_front();
            checkOutput("read-to-write latency", DW'(cyc - rc), DW'(L + 1));
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $finish;
  end

  // Directed scenarios.
  initial begin
    int g0, t0, wc0;
    #1;
    for (int a = 0; a < 128; a++) preload(7'(a), '0);
    checkReset("power-on");
    rst = 1'b0;

    $display("[TB] single local write");
    preload(7'd5, {32'd10, 32'd10, 32'd10});
    expectWrite(7'd5, {32'd11, 32'd12, 32'd13});
    g0 = glog.size();
    applyStimulus(1'b0, 7'd5, {32'd1, 32'd2, 32'd3});
    waitGrants(g0 + 1);
    t0 = glog[g0].cyc;
    checkOutput("t1 grant side", DW'(glog[g0].who), '0);
    while (cyc < t0 + 3) tick();
    checkOutput("t1 wb_idle at T+3", DW'(wb_idle), '0);
    tick();
    checkOutput("t1 wb_idle at T+4", DW'(wb_idle), DW'(1));
    waitIdle();

    $display("[TB] back-to-back same pid");
    expectWrite(7'd5, {32'd12, 32'd13, 32'd14});
    expectWrite(7'd5, {32'd14, 32'd15, 32'd16});
    g0 = glog.size();
    applyStimulus(1'b0, 7'd5, {32'd1, 32'd1, 32'd1});
    applyStimulus(1'b0, 7'd5, {32'd2, 32'd2, 32'd2});
    waitGrants(g0 + 2);
    checkOutput("t2 grant spacing >= 4", DW'((glog[g0+1].cyc - glog[g0].cyc) >= 4), DW'(1));
    waitIdle();

    $display("[TB] alternating distinct pids");
    doReset();
    preload(7'd5, '0);
    g0 = glog.size();
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 7'(k), {3{32'(k)}});
      applyStimulus(1'b1, 7'(k + 8), {3{32'(k + 8)}});
      expectWrite(7'(k), {3{32'(k)}});
      expectWrite(7'(k + 8), {3{32'(k + 8)}});
    end
    waitGrants(g0 + 16);
    waitIdle();
    for (int i = 0; i < 16; i++) begin
      checkOutput("t3 grant side order", DW'(glog[g0+i].who), DW'(i % 2));
      checkOutput("t3 grant every cycle", DW'(glog[g0+i].cyc - glog[g0].cyc), DW'(i));
    end

    $display("[TB] equal pid collision");
    doReset();
    preload(7'd7, {32'd100, 32'd200, 32'd300});
    g0 = glog.size();
`ifdef FORCE_WB_MERGE_EN
    expectWrite(7'd7, {32'd111, 32'd222, 32'd333});
`else
    expectWrite(7'd7, {32'd101, 32'd202, 32'd303});
    expectWrite(7'd7, {32'd111, 32'd222, 32'd333});
`endif
    applyStimulus(1'b0, 7'd7, {32'd1, 32'd2, 32'd3});
    applyStimulus(1'b1, 7'd7, {32'd10, 32'd20, 32'd30});
    waitGrants(g0 + 2);
    waitIdle();
    checkOutput("t4 first grant local", DW'(glog[g0].who), '0);
    checkOutput("t4 second grant remote", DW'(glog[g0+1].who), DW'(1));
`ifdef FORCE_WB_MERGE_EN
    checkOutput("t4 merged grant same cycle", DW'(glog[g0+1].cyc - glog[g0].cyc), '0);
`else
    checkOutput("t4 remote grant at T+4", DW'(glog[g0+1].cyc - glog[g0].cyc), DW'(4));
`endif

    $display("[TB] per-component wrap");
    preload(7'd20, {32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    expectWrite(7'd20, {32'd6, 32'd0, 32'd1});
    applyStimulus(1'b1, 7'd20, {32'd1, 32'd1, 32'd2});
    waitIdle();

    $display("[TB] reset during flight");
    g0 = glog.size();
    applyStimulus(1'b0, 7'd30, {32'd1, 32'd1, 32'd1});
    waitGrants(g0 + 1);
    rst = 1'b1;
    wc0 = wr_count;
    tick();
    checkReset("mid-flight reset");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("t6 no write after reset", DW'(wr_count), DW'(wc0));
    checkOutput("t6 wb_idle after reset", DW'(wb_idle), DW'(1));
    checkOutput("t6 cache_wr_en after reset", DW'(cache_wr_en), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
